// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 interrupt-acknowledge logic: sequencer states,
// default handshake timing and the vector width.
package pic_pkg;

    localparam int VEC_W         = 8;
    localparam int DEF_PULSE_W   = 2;
    localparam int DEF_GAP_W     = 2;
    localparam int DEF_RECOVER_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE1  = 3'd1,
        GAP     = 3'd2,
        PULSE2  = 3'd3,
        HOLD    = 3'd4,
        RECOVER = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // NOTE: non-blocking assignment lets each stage sample the other's pre-edge value;
    // with blocking assignment the two stages would collapse into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side initiator of the 8259 two-pulse INTA handshake; captures the vector
// driven during pulse 2 and offers it to the core on a valid/ack handshake.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int GAP_W     = DEF_GAP_W,
    parameter int RECOVER_W = DEF_RECOVER_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             INT,
    input  logic             int_enable,
    input  logic [VEC_W-1:0] DataBusIn,
    output logic             INTA_n,
    output logic             lock,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    input  logic             vector_ack,
    output logic             busy
);

    localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, RECOVER_W)) + 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_W - 1);

    logic             rst_n;
    logic             int_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inta_n_q, inta_n_d;
    logic             lock_q, lock_d;
    logic             valid_q, valid_d;
    logic [VEC_W-1:0] vector_q, vector_d;

    // Reset asserts asynchronously but releases on a clock edge.
    sync_2ff u_rst_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (1'b1),
        .q_o   (rst_n)
    );

    sync_2ff u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (INT),
        .q_o   (int_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (int_s && int_enable) begin
                    state_d = PULSE1;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE1: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE2;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE2: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (vector_ack) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LOAD;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop glitch-free.
    always_comb begin
        inta_n_d = !((state_d == PULSE1) || (state_d == PULSE2));
        lock_d   = (state_d == PULSE1) || (state_d == GAP) || (state_d == PULSE2);
        valid_d  = (state_d == HOLD);
        vector_d = ((state_q == PULSE2) && (state_d == HOLD)) ? DataBusIn : vector_q;
    end

    // NOTE: vector_q is reset although it is datapath, so the core never sees a
    // stale interrupt type left over from before a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            lock_q   <= 1'b0;
            valid_q  <= 1'b0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            lock_q   <= lock_d;
            valid_q  <= valid_d;
            vector_q <= vector_d;
        end
    end

    assign INTA_n       = inta_n_q;
    assign lock         = lock_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default timing instance plus a 1/1/1 instance.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       INT, int_enable, vector_ack;
    logic [7:0] DataBusIn;
    logic       INTA_n, lock, vector_valid, busy;
    logic [7:0] vector;

    logic       f_int, f_en, f_ack;
    logic [7:0] f_data;
    logic       f_inta_n, f_lock, f_valid, f_busy;
    logic [7:0] f_vector;

    int errors = 0;
    int checks = 0;
    logic found;

    always #5 clk = ~clk;

    inta_sequencer u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .INT          (INT),
        .int_enable   (int_enable),
        .DataBusIn    (DataBusIn),
        .INTA_n       (INTA_n),
        .lock         (lock),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ack   (vector_ack),
        .busy         (busy)
    );

    inta_sequencer #(.PULSE_W(1), .GAP_W(1), .RECOVER_W(1)) u_fast (
        .clk          (clk),
        .reset_n      (reset_n),
        .INT          (f_int),
        .int_enable   (f_en),
        .DataBusIn    (f_data),
        .INTA_n       (f_inta_n),
        .lock         (f_lock),
        .vector       (f_vector),
        .vector_valid (f_valid),
        .vector_ack   (f_ack),
        .busy         (f_busy)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1; INT = 1'b0; int_enable = 1'b0; vector_ack = 1'b0; DataBusIn = 8'h00;
        f_int = 1'b0; f_en = 1'b0; f_ack = 1'b0; f_data = 8'h00;
        #2 reset_n = 1'b0;
        step(3);
        chk1("rst_inta_n", INTA_n, 1'b1);
        chk1("rst_lock", lock, 1'b0);
        chk8("rst_vector", vector, 8'h00);
        chk1("rst_valid", vector_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step(4);

        // Test 1: default timing, vector 48h.
        int_enable = 1'b1; DataBusIn = 8'hFF;
        INT = 1'b1;
        step(2);
        chk1("t1_idle_inta_n", INTA_n, 1'b1);
        chk1("t1_idle_busy", busy, 1'b0);
        step(1);
        chk1("t1_p1a_inta_n", INTA_n, 1'b0);
        chk1("t1_p1a_lock", lock, 1'b1);
        chk1("t1_p1a_busy", busy, 1'b1);
        step(1);
        chk1("t1_p1b_inta_n", INTA_n, 1'b0);
        step(1);
        chk1("t1_gapa_inta_n", INTA_n, 1'b1);
        chk1("t1_gapa_lock", lock, 1'b1);
        step(1);
        chk1("t1_gapb_inta_n", INTA_n, 1'b1);
        chk1("t1_gapb_lock", lock, 1'b1);
        step(1);
        chk1("t1_p2a_inta_n", INTA_n, 1'b0);
        DataBusIn = 8'h48;
        step(1);
        chk1("t1_p2b_inta_n", INTA_n, 1'b0);
        chk1("t1_p2b_valid", vector_valid, 1'b0);
        step(1);
        chk1("t1_hold_valid", vector_valid, 1'b1);
        chk8("t1_hold_vector", vector, 8'h48);
        chk1("t1_hold_inta_n", INTA_n, 1'b1);
        chk1("t1_hold_lock", lock, 1'b0);
        DataBusIn = 8'h00; vector_ack = 1'b1;
        step(1);
        chk1("t1_ack_valid", vector_valid, 1'b0);
        chk1("t1_ack_busy", busy, 1'b1);
        chk8("t1_ack_vector", vector, 8'h48);
        vector_ack = 1'b0; INT = 1'b0;
        step(2);
        chk1("t1_rec_busy", busy, 1'b1);
        step(1);
        chk1("t1_idle_after_busy", busy, 1'b0);
        step(5);
        chk1("t1_quiet_inta_n", INTA_n, 1'b1);

        // Test 2: INT high but interrupts disabled.
        INT = 1'b1; int_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk1("t2_disabled_inta_n", INTA_n, 1'b1);
            chk1("t2_disabled_busy", busy, 1'b0);
        end
        int_enable = 1'b1;
        step(1);
        chk1("t2_enable_inta_n", INTA_n, 1'b0);
        chk1("t2_enable_lock", lock, 1'b1);

        // Test 3: INT drops during GAP; pulse 2 still runs.
        step(2);
        chk1("t3_gap_inta_n", INTA_n, 1'b1);
        INT = 1'b0;
        step(2);
        chk1("t3_p2_inta_n", INTA_n, 1'b0);
        DataBusIn = 8'h4F;
        step(1);
        chk1("t3_p2b_inta_n", INTA_n, 1'b0);
        step(1);
        chk1("t3_valid", vector_valid, 1'b1);
        chk8("t3_vector", vector, 8'h4F);
        chk1("t3_busy", busy, 1'b1);
        INT = 1'b1; DataBusIn = 8'h11;

        // Test 4: no ack for 10 cycles, then ack; INT high retriggers.
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk1("t4_hold_valid", vector_valid, 1'b1);
            chk8("t4_hold_vector", vector, 8'h4F);
            chk1("t4_hold_busy", busy, 1'b1);
            chk1("t4_hold_inta_n", INTA_n, 1'b1);
        end
        vector_ack = 1'b1;
        step(1);
        chk1("t4_ack_valid", vector_valid, 1'b0);
        chk1("t4_ack_busy", busy, 1'b1);
        chk8("t4_ack_vector", vector, 8'h4F);
        vector_ack = 1'b0;
        step(2);
        chk1("t4_rec3_busy", busy, 1'b1);
        step(1);
        chk1("t4_idle_busy", busy, 1'b0);
        chk1("t4_idle_inta_n", INTA_n, 1'b1);
        step(1);
        chk1("t4_retrig_inta_n", INTA_n, 1'b0);
        chk1("t4_retrig_lock", lock, 1'b1);

        // Test 5: reset mid-PULSE2.
        step(4);
        chk1("t5_p2_inta_n", INTA_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk1("t5_rst_inta_n", INTA_n, 1'b1);
        chk1("t5_rst_lock", lock, 1'b0);
        chk1("t5_rst_valid", vector_valid, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk8("t5_rst_vector", vector, 8'h00);
        step(2);
        reset_n = 1'b1; DataBusIn = 8'h5A;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (INTA_n === 1'b0) found = 1'b1;
        end
        chk1("t5_restart_seen", found, 1'b1);
        chk1("t5_restart_lock", lock, 1'b1);
        step(1);
        chk1("t5_p1b_inta_n", INTA_n, 1'b0);
        step(1);
        chk1("t5_gap_inta_n", INTA_n, 1'b1);
        INT = 1'b0; vector_ack = 1'b1;
        step(2);
        chk1("t5_p2_inta_n2", INTA_n, 1'b0);
        step(2);
        chk1("t5_valid", vector_valid, 1'b1);
        chk8("t5_vector", vector, 8'h5A);
        step(1);
        chk1("t5_early_ack_valid", vector_valid, 1'b0);
        chk1("t5_early_ack_busy", busy, 1'b1);
        vector_ack = 1'b0;
        step(5);

        // Test 6: single-cycle timing instance.
        f_en = 1'b1; f_ack = 1'b1; f_data = 8'hEE;
        f_int = 1'b1;
        step(2);
        chk1("t6_idle_busy", f_busy, 1'b0);
        step(1);
        chk1("t6_p1_inta_n", f_inta_n, 1'b0);
        chk1("t6_p1_lock", f_lock, 1'b1);
        step(1);
        chk1("t6_gap_inta_n", f_inta_n, 1'b1);
        chk1("t6_gap_lock", f_lock, 1'b1);
        step(1);
        chk1("t6_p2_inta_n", f_inta_n, 1'b0);
        f_data = 8'hC3;
        step(1);
        chk1("t6_valid", f_valid, 1'b1);
        chk8("t6_vector", f_vector, 8'hC3);
        chk1("t6_hold_lock", f_lock, 1'b0);
        step(1);
        chk1("t6_rec_valid", f_valid, 1'b0);
        chk1("t6_rec_busy", f_busy, 1'b1);
        step(1);
        chk1("t6_idle_busy2", f_busy, 1'b0);
        chk1("t6_idle_inta_n", f_inta_n, 1'b1);
        step(1);
        chk1("t6_b2b_inta_n", f_inta_n, 1'b0);
        step(1);
        chk1("t6_b2b_gap", f_inta_n, 1'b1);
        step(1);
        chk1("t6_b2b_p2", f_inta_n, 1'b0);
        f_data = 8'h3C;
        step(1);
        chk1("t6_b2b_valid", f_valid, 1'b1);
        chk8("t6_b2b_vector", f_vector, 8'h3C);
        f_int = 1'b0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
